// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART types and message strings.
//   uart_fifo_mode_e : read-side mode of uart_sync_fifo
//                      (registered read or first-word-fall-through).
//   MSG_*            : elaboration diagnostics used by the UART blocks.
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic {
        FIFO_MODE_STD  = 1'b0,
        FIFO_MODE_FWFT = 1'b1
    } uart_fifo_mode_e;

    localparam string MSG_BAD_DW = "uart_sync_fifo: FIFO_DW must be >= 1";
    localparam string MSG_BAD_AW = "uart_sync_fifo: FIFO_AW must be >= 1";

endpackage

// File: rtl/uart_sync_fifo_if.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo_if
// Push/pop data path of uart_sync_fifo.
//   i_wr_req, i_data_in, i_par_inject : push side (driven by master)
//   i_rd_req                          : pop request (driven by master)
//   o_data_out, o_valid               : read data (driven by slave = FIFO)
// ----------------------------------------------------------------------------
interface uart_sync_fifo_if #(
    parameter int unsigned FIFO_DW = 8
);
    logic               i_wr_req;
    logic [FIFO_DW-1:0] i_data_in;
    logic               i_par_inject;
    logic               i_rd_req;
    logic [FIFO_DW-1:0] o_data_out;
    logic               o_valid;

    modport master (
        output i_wr_req, i_data_in, i_par_inject, i_rd_req,
        input  o_data_out, o_valid
    );

    modport slave (
        input  i_wr_req, i_data_in, i_par_inject, i_rd_req,
        output o_data_out, o_valid
    );
endinterface

// File: rtl/uart_fifo_mem.sv
// ----------------------------------------------------------------------------
// uart_fifo_mem
// FIFO storage array: 2**AW words of DW bits, synchronous write,
// asynchronous read. Contents are not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// ----------------------------------------------------------------------------
module uart_fifo_mem #(
    parameter int unsigned DW = 9,
    parameter int unsigned AW = 2
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO with optional per-word even parity, STD or FWFT read,
// programmable almost-full/almost-empty flags and sticky error flags.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   bus (slave)       : push/pop data path (see uart_sync_fifo_if)
//   i_flush           : discard contents (pointers, count, valid)
//   i_af_thresh       : almost-full threshold  (o_used >= thresh)
//   i_ae_thresh       : almost-empty threshold (o_used <= thresh)
//   i_clr_err         : clear sticky flags (a new set wins)
//   o_used, o_free    : occupied / free entries, 0..DEPTH
//   o_full, o_empty, o_almost_full, o_almost_empty : status
//   o_parity_error    : parity mismatch on o_data_out (valid only with o_valid)
//   o_overflow, o_underflow, o_parity_sticky       : sticky errors
// ----------------------------------------------------------------------------
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned     FIFO_DW            = 8,
    parameter int unsigned     FIFO_AW            = 2,
    parameter bit              FIFO_PARITY_ENABLE = 1'b1,
    parameter uart_fifo_mode_e FIFO_MODE          = FIFO_MODE_STD
) (
    input  logic               i_clk,
    input  logic               i_rst,
    uart_sync_fifo_if.slave    bus,
    input  logic               i_flush,
    input  logic [FIFO_AW:0]   i_af_thresh,
    input  logic [FIFO_AW:0]   i_ae_thresh,
    input  logic               i_clr_err,
    output logic [FIFO_AW:0]   o_used,
    output logic [FIFO_AW:0]   o_free,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic               o_parity_error,
    output logic               o_overflow,
    output logic               o_underflow,
    output logic               o_parity_sticky
);
    if (FIFO_DW < 1) begin : g_bad_dw
        $error("%s", MSG_BAD_DW);
    end
    if (FIFO_AW < 1) begin : g_bad_aw
        $error("%s", MSG_BAD_AW);
    end

    localparam int unsigned  PW    = FIFO_PARITY_ENABLE ? 1 : 0;
    localparam int unsigned  MW    = FIFO_DW + PW;
    localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_used;
    logic               r_ovf;
    logic               r_unf;
    logic               r_psticky;

    logic               w_push;
    logic               w_pop;
    logic [MW-1:0]      w_wdata;
    logic [MW-1:0]      w_rdata;
    logic [FIFO_DW-1:0] w_head_data;
    logic               w_head_par;
    logic [FIFO_DW-1:0] w_out_data;
    logic               w_out_par;
    logic               w_out_valid;

    // Flush overrides both sides; full/empty gate the respective side only,
    // so a full FIFO still pops and an empty FIFO still pushes.
    assign w_push = bus.i_wr_req && !o_full  && !i_flush;
    assign w_pop  = bus.i_rd_req && !o_empty && !i_flush;

    if (FIFO_PARITY_ENABLE) begin : g_par
        assign w_wdata    = {(^bus.i_data_in) ^ bus.i_par_inject, bus.i_data_in};
        assign w_head_par = w_rdata[FIFO_DW];
    end else begin : g_nopar
        assign w_wdata    = bus.i_data_in;
        assign w_head_par = 1'b0;
    end
    assign w_head_data = w_rdata[FIFO_DW-1:0];

    uart_fifo_mem #(
        .DW (MW),
        .AW (FIFO_AW)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_used    <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_psticky <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_used <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_used <= r_used + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_used <= r_used - 1'b1;
                end
            end
            r_ovf     <= (bus.i_wr_req && o_full  && !i_flush) || (r_ovf && !i_clr_err);
            r_unf     <= (bus.i_rd_req && o_empty && !i_flush) || (r_unf && !i_clr_err);
            r_psticky <= (w_out_valid && o_parity_error) || (r_psticky && !i_clr_err);
        end
    end

    if (FIFO_MODE == FIFO_MODE_FWFT) begin : g_fwft
        // Head shown directly from storage; zeroed while empty so the output
        // is defined after reset even though the array is not.
        assign w_out_valid = !o_empty;
        assign w_out_data  = o_empty ? '0   : w_head_data;
        assign w_out_par   = o_empty ? 1'b0 : w_head_par;
    end else begin : g_std
        logic [FIFO_DW-1:0] r_dout;
        logic               r_dpar;
        logic               r_valid;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_dout  <= '0;
                r_dpar  <= 1'b0;
                r_valid <= 1'b0;
            end else if (i_flush) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_pop;
                if (w_pop) begin
                    r_dout <= w_head_data;
                    r_dpar <= w_head_par;
                end
            end
        end

        assign w_out_valid = r_valid;
        assign w_out_data  = r_dout;
        assign w_out_par   = r_dpar;
    end

    assign bus.o_data_out = w_out_data;
    assign bus.o_valid    = w_out_valid;
    assign o_parity_error = FIFO_PARITY_ENABLE ? (w_out_par ^ (^w_out_data)) : 1'b0;

    assign o_used         = r_used;
    assign o_free         = DEPTH - r_used;
    assign o_full         = (r_used == DEPTH);
    assign o_empty        = (r_used == '0);
    assign o_almost_full  = (r_used >= i_af_thresh);
    assign o_almost_empty = (r_used <= i_ae_thresh);
    assign o_overflow     = r_ovf;
    assign o_underflow    = r_unf;
    assign o_parity_sticky = r_psticky;
endmodule

// File: tb/tb_uart_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_sync_fifo
// Self-checking bench: one STD instance driven from a vector table with a
// queue scoreboard for read data, one FWFT instance driven by hand.
// ----------------------------------------------------------------------------
module tb_uart_sync_fifo;
    import uart_pkg::*;

    typedef struct {
        logic [7:0] d;
        logic       inj;
    } word_t;

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       inj;
        logic       rd;
        logic       fl;
        logic       clr;
        int         used;
        logic       ovf;
        logic       unf;
        logic       ps;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       clr_err;
    logic [2:0] af_thresh;
    logic [2:0] ae_thresh;

    logic [2:0] s_used, s_free, f_used, f_free;
    logic s_full, s_empty, s_af, s_ae, s_perr, s_ovf, s_unf, s_ps;
    logic f_full, f_empty, f_af, f_ae, f_perr, f_ovf, f_unf, f_ps;

    uart_sync_fifo_if #(.FIFO_DW(8)) bus_s ();
    uart_sync_fifo_if #(.FIFO_DW(8)) bus_f ();

    uart_sync_fifo #(
        .FIFO_DW            (8),
        .FIFO_AW            (2),
        .FIFO_PARITY_ENABLE (1'b1),
        .FIFO_MODE          (FIFO_MODE_STD)
    ) dut_std (
        .i_clk           (clk),
        .i_rst           (rst),
        .bus             (bus_s.slave),
        .i_flush         (flush),
        .i_af_thresh     (af_thresh),
        .i_ae_thresh     (ae_thresh),
        .i_clr_err       (clr_err),
        .o_used          (s_used),
        .o_free          (s_free),
        .o_full          (s_full),
        .o_empty         (s_empty),
        .o_almost_full   (s_af),
        .o_almost_empty  (s_ae),
        .o_parity_error  (s_perr),
        .o_overflow      (s_ovf),
        .o_underflow     (s_unf),
        .o_parity_sticky (s_ps)
    );

    uart_sync_fifo #(
        .FIFO_DW            (8),
        .FIFO_AW            (2),
        .FIFO_PARITY_ENABLE (1'b1),
        .FIFO_MODE          (FIFO_MODE_FWFT)
    ) dut_fwft (
        .i_clk           (clk),
        .i_rst           (rst),
        .bus             (bus_f.slave),
        .i_flush         (flush),
        .i_af_thresh     (af_thresh),
        .i_ae_thresh     (ae_thresh),
        .i_clr_err       (clr_err),
        .o_used          (f_used),
        .o_free          (f_free),
        .o_full          (f_full),
        .o_empty         (f_empty),
        .o_almost_full   (f_af),
        .o_almost_empty  (f_ae),
        .o_parity_error  (f_perr),
        .o_overflow      (f_ovf),
        .o_underflow     (f_unf),
        .o_parity_sticky (f_ps)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_tests = 0;
    int    n_fail  = 0;
    word_t m_q[$];
    word_t exp_q[$];
    vec_t  vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [7:0] din, input logic inj, input logic rd,
                       input logic fl, input logic clr, input int used, input logic ovf,
                       input logic unf, input logic ps);
        vecs.push_back('{wr, din, inj, rd, fl, clr, used, ovf, unf, ps});
    endtask

    // Drive one cycle on the STD instance; the bench's own queue decides
    // acceptance and the expected read word, compared one cycle later.
    task automatic step_std(input string tag, input logic wr, input logic [7:0] din,
                            input logic inj, input logic rd, input logic fl, input logic clr);
        logic  push_ok;
        logic  pop_ok;
        word_t w;
        bus_s.i_wr_req     = wr;
        bus_s.i_data_in    = din;
        bus_s.i_par_inject = inj;
        bus_s.i_rd_req     = rd;
        flush              = fl;
        clr_err            = clr;
        push_ok = wr && (m_q.size() < 4) && !fl;
        pop_ok  = rd && (m_q.size() > 0) && !fl;
        if (pop_ok) exp_q.push_back(m_q.pop_front());
        if (push_ok) m_q.push_back('{din, inj});
        if (fl) m_q.delete();
        @(posedge clk);
        #1;
        check({tag, " valid"}, {31'd0, bus_s.o_valid}, {31'd0, pop_ok});
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check({tag, " data"}, {24'd0, bus_s.o_data_out}, {24'd0, w.d});
            check({tag, " perr"}, {31'd0, s_perr}, {31'd0, w.inj});
        end
    endtask

    task automatic check_std_reset(input string tag);
        check({tag, " used"},  {29'd0, s_used}, 32'd0);
        check({tag, " free"},  {29'd0, s_free}, 32'd4);
        check({tag, " empty"}, {31'd0, s_empty}, 32'd1);
        check({tag, " full"},  {31'd0, s_full}, 32'd0);
        check({tag, " valid"}, {31'd0, bus_s.o_valid}, 32'd0);
        check({tag, " data"},  {24'd0, bus_s.o_data_out}, 32'd0);
        check({tag, " sticky"}, {29'd0, s_ovf, s_unf, s_ps}, 32'd0);
        check({tag, " ae"},    {31'd0, s_ae}, 32'd1);
        check({tag, " af"},    {31'd0, s_af}, 32'd0);
    endtask

    initial begin
        string tag;
        int    u;
        af_thresh = 3'd3;
        ae_thresh = 3'd1;
        flush     = 1'b0;
        clr_err   = 1'b0;
        bus_s.i_wr_req = 1'b0; bus_s.i_data_in = '0; bus_s.i_par_inject = 1'b0;
        bus_s.i_rd_req = 1'b0;
        bus_f.i_wr_req = 1'b0; bus_f.i_data_in = '0; bus_f.i_par_inject = 1'b0;
        bus_f.i_rd_req = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_std_reset("reset");
        check("fwft reset valid", {31'd0, bus_f.o_valid}, 32'd0);
        check("fwft reset data", {24'd0, bus_f.o_data_out}, 32'd0);

        // Fill, overflow, drain
        add(1, 8'h11, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h22, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 8'h33, 0, 0, 0, 0, 3, 0, 0, 0);
        add(1, 8'h44, 0, 0, 0, 0, 4, 0, 0, 0);
        add(1, 8'h55, 0, 0, 0, 0, 4, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 3, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 2, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
        // Simultaneous push+pop across pointer wrap
        add(1, 8'hAA, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'hBB, 0, 0, 0, 0, 2, 0, 0, 0);
        for (int k = 0; k < 6; k++) add(1, 8'hC0 + 8'(k), 0, 1, 0, 0, 2, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        // Underflow on empty push+pop, clear, set-wins-over-clear
        add(1, 8'hA5, 0, 1, 0, 0, 1, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 0, 0, 1, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
        // Injected parity error in STD mode
        add(1, 8'h0F, 1, 0, 0, 0, 1, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 0, 0);
        // Flush at used=3 with push+pop, then refill
        add(1, 8'h01, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 8'h02, 0, 0, 0, 0, 2, 0, 0, 0);
        add(1, 8'h03, 0, 0, 0, 0, 3, 0, 0, 0);
        add(1, 8'h09, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 8'h04, 0, 0, 0, 0, 1, 0, 1, 0);
        add(1, 8'h05, 0, 0, 0, 0, 2, 0, 1, 0);

        foreach (vecs[i]) begin
            tag = $sformatf("v%0d", i);
            step_std(tag, vecs[i].wr, vecs[i].din, vecs[i].inj, vecs[i].rd, vecs[i].fl,
                     vecs[i].clr);
            u = vecs[i].used;
            check({tag, " used"},  {29'd0, s_used}, u);
            check({tag, " free"},  {29'd0, s_free}, 4 - u);
            check({tag, " full"},  {31'd0, s_full}, (u == 4) ? 32'd1 : 32'd0);
            check({tag, " empty"}, {31'd0, s_empty}, (u == 0) ? 32'd1 : 32'd0);
            check({tag, " af"},    {31'd0, s_af}, (u >= 3) ? 32'd1 : 32'd0);
            check({tag, " ae"},    {31'd0, s_ae}, (u <= 1) ? 32'd1 : 32'd0);
            check({tag, " ovf"},   {31'd0, s_ovf}, {31'd0, vecs[i].ovf});
            check({tag, " unf"},   {31'd0, s_unf}, {31'd0, vecs[i].unf});
            check({tag, " psticky"}, {31'd0, s_ps}, {31'd0, vecs[i].ps});
        end

        // Reset mid-stream dominates push/pop
        bus_s.i_wr_req = 1'b1; bus_s.i_data_in = 8'h66; bus_s.i_rd_req = 1'b1;
        flush = 1'b1; clr_err = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
        bus_s.i_wr_req = 1'b0; bus_s.i_rd_req = 1'b0;
        m_q.delete();
        exp_q.delete();
        check_std_reset("midrst");

        // FWFT: head visible without pop, parity inject on second word
        bus_f.i_wr_req = 1'b1; bus_f.i_data_in = 8'h3C; bus_f.i_par_inject = 1'b0;
        @(posedge clk);
        #1;
        check("fwft valid0", {31'd0, bus_f.o_valid}, 32'd1);
        check("fwft data0", {24'd0, bus_f.o_data_out}, 32'h3C);
        check("fwft perr0", {31'd0, f_perr}, 32'd0);
        check("fwft used0", {29'd0, f_used}, 32'd1);
        bus_f.i_data_in = 8'h7E; bus_f.i_par_inject = 1'b1; bus_f.i_rd_req = 1'b1;
        @(posedge clk);
        #1;
        bus_f.i_wr_req = 1'b0; bus_f.i_par_inject = 1'b0; bus_f.i_rd_req = 1'b0;
        check("fwft valid1", {31'd0, bus_f.o_valid}, 32'd1);
        check("fwft data1", {24'd0, bus_f.o_data_out}, 32'h7E);
        check("fwft perr1", {31'd0, f_perr}, 32'd1);
        check("fwft used1", {29'd0, f_used}, 32'd1);
        @(posedge clk);
        #1;
        check("fwft psticky", {31'd0, f_ps}, 32'd1);
        bus_f.i_rd_req = 1'b1;
        @(posedge clk);
        #1;
        bus_f.i_rd_req = 1'b0;
        check("fwft drained valid", {31'd0, bus_f.o_valid}, 32'd0);
        check("fwft drained empty", {31'd0, f_empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
